// File: rtl/secure_scan_sequencer.sv
// ---------------------------------------------------------------------------
// secure_scan_sequencer
//
// Runs one complete scan-test session on the AES core scan chain (shift-in,
// capture, shift-out) from a single scan_start pulse.  It also holds the
// sticky secure-lock latch: once secure_mode is seen, scan stays disabled
// and functional key load stays enabled until reset_n.
//
// Optional build macro: SECURE_ZEROIZE_EN
//   When defined, a secure_mode event first passes through a ZEROIZE state
//   that holds the extra output `zeroize` high for ZERO_CYCLES cycles before
//   LOCK is reached.  When undefined, secure_mode enters LOCK directly and
//   the `zeroize` port does not exist.
//
// Parameters:
//   CHAIN_LEN      scan chain length (shift cycles per phase), >= 1
//   CAPTURE_CYCLES functional cycles held in CAPTURE, >= 1
//   ZERO_CYCLES    zeroize pulse length (SECURE_ZEROIZE_EN only), >= 1
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   test_mode    in   tester requests test access (level)
//   secure_mode  in   lock request; a single-cycle high is enough
//   scan_start   in   one-cycle pulse, starts a session from IDLE
//   scan_in_en   out  chain accepts serial input (SHIFT_IN)
//   scan_out_en  out  chain serial output observable (SHIFT_OUT)
//   scan_mode    out  scan muxes select chain path (shift phases)
//   scan_capture out  capture cycle in progress
//   scan_busy    out  session active (shift/capture phases)
//   scan_done    out  one-cycle pulse, session completed
//   scan_abort   out  one-cycle pulse, session aborted
//   loadkey      out  functional key load permitted
//   locked       out  secure lock active
//   zeroize      out  chain/state clear pulse (SECURE_ZEROIZE_EN only)
//   shift_count  out  shift index within the current shift phase
// ---------------------------------------------------------------------------
module secure_scan_sequencer #(
  parameter int CHAIN_LEN      = 128,
  parameter int CAPTURE_CYCLES = 1,
  parameter int ZERO_CYCLES    = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               test_mode,
  input  logic                               secure_mode,
  input  logic                               scan_start,
  output logic                               scan_in_en,
  output logic                               scan_out_en,
  output logic                               scan_mode,
  output logic                               scan_capture,
  output logic                               scan_busy,
  output logic                               scan_done,
  output logic                               scan_abort,
  output logic                               loadkey,
  output logic                               locked,
`ifdef SECURE_ZEROIZE_EN
  output logic                               zeroize,
`endif
  output logic [$clog2(CHAIN_LEN+1)-1:0]     shift_count
);

  // One shared phase counter covers shift, capture and zeroize phases, so
  // it is sized for the longest of them.
  localparam int MAX_A   = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int MAX_CNT = (MAX_A > ZERO_CYCLES) ? MAX_A : ZERO_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int SC_W    = $clog2(CHAIN_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE,
    S_LOCK,
    S_ZEROIZE
  } state_t;

`ifdef SECURE_ZEROIZE_EN
  localparam state_t S_LOCK_ENTRY = S_ZEROIZE;
`else
  localparam state_t S_LOCK_ENTRY = S_LOCK;
`endif

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_abort_next;
  logic               w_active;

  // Next-state decision.  Priority: secure_mode, then test_mode low, then
  // the normal sequence.  LOCK (and ZEROIZE, once entered) ignore inputs.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_abort_next = 1'b0;
    w_active     = (r_state == S_SHIFT_IN) || (r_state == S_CAPTURE) ||
                   (r_state == S_SHIFT_OUT);

    if (r_state == S_LOCK) begin
      w_state_next = S_LOCK;
      w_cnt_next   = '0;
`ifdef SECURE_ZEROIZE_EN
    end else if (r_state == S_ZEROIZE) begin
      if (r_cnt == CNT_W'(ZERO_CYCLES - 1)) begin
        w_state_next = S_LOCK;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
`endif
    end else if (secure_mode) begin
      w_state_next = S_LOCK_ENTRY;
      w_cnt_next   = '0;
      w_abort_next = w_active;
    end else if (w_active && !test_mode) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_abort_next = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan_start && test_mode) begin
            w_state_next = S_SHIFT_IN;
            w_cnt_next   = '0;
          end
        end
        S_SHIFT_IN: begin
          if (r_cnt == CNT_W'(CHAIN_LEN - 1)) begin
            w_state_next = S_CAPTURE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (r_cnt == CNT_W'(CAPTURE_CYCLES - 1)) begin
            w_state_next = S_SHIFT_OUT;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        S_SHIFT_OUT: begin
          if (r_cnt == CNT_W'(CHAIN_LEN - 1)) begin
            w_state_next = S_DONE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // State register plus registered outputs decoded from the next state, so
  // every output changes on the same edge as the state it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      scan_in_en   <= 1'b0;
      scan_out_en  <= 1'b0;
      scan_mode    <= 1'b0;
      scan_capture <= 1'b0;
      scan_busy    <= 1'b0;
      scan_done    <= 1'b0;
      scan_abort   <= 1'b0;
      loadkey      <= 1'b0;
      locked       <= 1'b0;
`ifdef SECURE_ZEROIZE_EN
      zeroize      <= 1'b0;
`endif
      shift_count  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      scan_in_en   <= (w_state_next == S_SHIFT_IN);
      scan_out_en  <= (w_state_next == S_SHIFT_OUT);
      scan_mode    <= (w_state_next == S_SHIFT_IN) || (w_state_next == S_SHIFT_OUT);
      scan_capture <= (w_state_next == S_CAPTURE);
      scan_busy    <= (w_state_next == S_SHIFT_IN) || (w_state_next == S_CAPTURE) ||
                      (w_state_next == S_SHIFT_OUT);
      scan_done    <= (w_state_next == S_DONE);
      scan_abort   <= w_abort_next;
      loadkey      <= (w_state_next == S_LOCK);
      locked       <= (w_state_next == S_LOCK) || (w_state_next == S_ZEROIZE);
`ifdef SECURE_ZEROIZE_EN
      zeroize      <= (w_state_next == S_ZEROIZE);
`endif
      // The counter never exceeds CHAIN_LEN-1 in a shift state, so the low
      // SC_W bits carry the whole value there.
      if ((w_state_next == S_SHIFT_IN) || (w_state_next == S_SHIFT_OUT))
        shift_count <= w_cnt_next[SC_W-1:0];
      else
        shift_count <= '0;
    end
  end

endmodule

// File: tb/tb_secure_scan_sequencer.sv
module tb_secure_scan_sequencer;

  localparam int N = 8;
  localparam int C = 1;
  localparam int Z = 4;
  localparam int BUSY_T = 2 * N + C;     // last busy cycle index of a session
  localparam int DONE_T = 2 * N + C + 1; // cycle index of the done pulse

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic test_mode = 1'b0;
  logic secure_mode = 1'b0;
  logic scan_start = 1'b0;
  logic scan_in_en, scan_out_en, scan_mode, scan_capture, scan_busy;
  logic scan_done, scan_abort, loadkey, locked;
`ifdef SECURE_ZEROIZE_EN
  logic zeroize;
`endif
  logic [$clog2(N+1)-1:0] shift_count;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  secure_scan_sequencer #(
    .CHAIN_LEN(N), .CAPTURE_CYCLES(C), .ZERO_CYCLES(Z)
  ) dut (
    .clk(clk), .reset_n(reset_n), .test_mode(test_mode),
    .secure_mode(secure_mode), .scan_start(scan_start),
    .scan_in_en(scan_in_en), .scan_out_en(scan_out_en), .scan_mode(scan_mode),
    .scan_capture(scan_capture), .scan_busy(scan_busy), .scan_done(scan_done),
    .scan_abort(scan_abort), .loadkey(loadkey), .locked(locked),
`ifdef SECURE_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .shift_count(shift_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // sess = cycles elapsed since the start edge (0 = no session running).
  int sess = 0;
  bit m_locked = 1'b0;
  int lock_age = 0;
  bit m_abort = 1'b0;
  bit m_in_sess;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sess = 0; m_locked = 1'b0; lock_age = 0; m_abort = 1'b0;
    end else begin
      m_in_sess = (sess >= 1) && (sess <= BUSY_T);
      m_abort = 1'b0;
      if (m_locked) begin
        if (lock_age < 1000) lock_age++;
      end else if (secure_mode) begin
        m_abort = m_in_sess; m_locked = 1'b1; lock_age = 0; sess = 0;
      end else if (m_in_sess && !test_mode) begin
        m_abort = 1'b1; sess = 0;
      end else if (m_in_sess) begin
        sess++;
      end else if (sess == DONE_T) begin
        sess = 0;
      end else if (scan_start && test_mode) begin
        sess = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit e_in, e_out, e_cap, e_busy, e_done, e_lk, e_zero;
  int e_cnt;
  always @(negedge clk) begin
    if (check_en && reset_n) begin
      e_in   = (sess >= 1) && (sess <= N);
      e_cap  = (sess > N) && (sess <= N + C);
      e_out  = (sess > N + C) && (sess <= BUSY_T);
      e_busy = (sess >= 1) && (sess <= BUSY_T);
      e_done = (sess == DONE_T);
      e_cnt  = e_in ? sess - 1 : (e_out ? sess - N - C - 1 : 0);
`ifdef SECURE_ZEROIZE_EN
      e_zero = m_locked && (lock_age < Z);
      e_lk   = m_locked && (lock_age >= Z);
      chk("zeroize", zeroize, e_zero);
`else
      e_zero = 1'b0;
      e_lk   = m_locked;
`endif
      chk("scan_in_en", scan_in_en, e_in);
      chk("scan_out_en", scan_out_en, e_out);
      chk("scan_mode", scan_mode, e_in | e_out);
      chk("scan_capture", scan_capture, e_cap);
      chk("scan_busy", scan_busy, e_busy);
      chk("scan_done", scan_done, e_done);
      chk("scan_abort", scan_abort, m_abort);
      chk("locked", locked, m_locked);
      chk("loadkey", loadkey, e_lk);
      chk("shift_count", shift_count, e_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Runs one session from the current negedge; counts phase lengths.
  task automatic run_session(input bit pulse_mid, output int done_at,
                             output int in_c, output int cap_c, output int out_c);
    done_at = 0; in_c = 0; cap_c = 0; out_c = 0;
    test_mode = 1'b1;
    scan_start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) scan_start = 1'b0;
      if (pulse_mid && k == 12) scan_start = 1'b1;
      if (pulse_mid && k == 13) scan_start = 1'b0;
      if (scan_in_en) in_c++;
      if (scan_capture) cap_c++;
      if (scan_out_en) out_c++;
      if (scan_done && done_at == 0) done_at = k;
      if (done_at != 0 && k == done_at + 1) chk("idle_after_done", scan_busy | scan_done, 0);
      if (done_at != 0 && k >= done_at + 2) break;
    end
    if (done_at == 0) chk("session_timeout", 0, 1);
  endtask

  task automatic wait_for(input string name, input int which, input int cnt);
    bit hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (which == 0 && scan_in_en && shift_count == cnt) begin hit = 1'b1; break; end
      if (which == 1 && scan_capture) begin hit = 1'b1; break; end
      if (which == 2 && scan_out_en && shift_count == cnt) begin hit = 1'b1; break; end
    end
    if (!hit) chk(name, 0, 1);
  endtask

  int d_at, ic, cc, oc;

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_scan_in_en", scan_in_en, 0);
    chk("rst_scan_busy", scan_busy, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_locked", locked, 0);
    chk("rst_loadkey", loadkey, 0);
    chk("rst_shift_count", shift_count, 0);
    reset_n = 1'b1;
    check_en = 1'b1;
    test_mode = 1'b1;
    tick();

    // plain session
    run_session(1'b0, d_at, ic, cc, oc);
    chk("done_cycle", d_at, 18);
    chk("in_cycles", ic, 8);
    chk("cap_cycles", cc, 1);
    chk("out_cycles", oc, 8);

    // scan_start with test_mode low is ignored
    test_mode = 1'b0; scan_start = 1'b1; tick(); scan_start = 1'b0; tick();
    chk("start_tm0_ignored", scan_busy, 0);
    test_mode = 1'b1; tick();

    // restart pulse during SHIFT_OUT leaves timing unchanged
    run_session(1'b1, d_at, ic, cc, oc);
    chk("done_cycle_restart", d_at, 18);
    chk("out_cycles_restart", oc, 8);
    repeat (3) tick();

    // secure_mode mid SHIFT_IN at shift_count 3
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    wait_for("wait_shift_in_3", 0, 3);
    secure_mode = 1'b1; tick(); secure_mode = 1'b0;
    chk("sec_abort", scan_abort, 1);
    chk("sec_in_en", scan_in_en, 0);
    chk("sec_locked", locked, 1);
`ifndef SECURE_ZEROIZE_EN
    chk("sec_loadkey", loadkey, 1);
`endif
    tick();
    chk("sec_abort_once", scan_abort, 0);
    scan_start = 1'b1; tick(); scan_start = 1'b0; repeat (2) tick();
    chk("locked_start_ignored", scan_busy, 0);
    #2 reset_n = 1'b0;
    #1 chk("unlock_locked", locked, 0);
    chk("unlock_loadkey", loadkey, 0);
    tick(); reset_n = 1'b1; tick();

    // test_mode dropped during CAPTURE
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    wait_for("wait_capture", 1, 0);
    test_mode = 1'b0; tick();
    chk("cap_abort", scan_abort, 1);
    chk("cap_no_done", scan_done, 0);
    chk("cap_shift_count", shift_count, 0);
    chk("cap_idle_busy", scan_busy, 0);
    test_mode = 1'b1; repeat (2) tick();

    // asynchronous reset mid SHIFT_OUT
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    wait_for("wait_shift_out_2", 2, 2);
    #2 reset_n = 1'b0;
    #1 chk("arst_out_en", scan_out_en, 0);
    chk("arst_mode", scan_mode, 0);
    chk("arst_busy", scan_busy, 0);
    chk("arst_shift_count", shift_count, 0);
    tick(); reset_n = 1'b1; tick();

`ifdef SECURE_ZEROIZE_EN
    begin
      int zc = 0;
      bit zok = 1'b1;
      secure_mode = 1'b1; tick(); secure_mode = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (zeroize) begin
          zc++;
          if (!locked || loadkey) zok = 1'b0;
        end
        if (!zeroize && zc != 0) break;
        tick();
      end
      chk("zero_cycles", zc, 4);
      chk("zero_flags", zok, 1);
      chk("zero_then_loadkey", loadkey, 1);
      #2 reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    end
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      test_mode   = ($urandom_range(0, 49) != 0);
      scan_start  = ($urandom_range(0, 5) == 0);
      secure_mode = ($urandom_range(0, 399) == 0);
      if (m_locked && lock_age > 10) begin
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      tick();
    end
    test_mode = 1'b0; scan_start = 1'b0; secure_mode = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
